// File: rtl/mdpt_update_ctrl.sv
// Update scheduler for the memory dependence prediction table: merges two request
// streams through a small FIFO onto the single mdpt write port and owns the clear sweep.
module mdpt_update_ctrl #(
  parameter int MDPT_ENTRIES    = 4096,
  parameter int MDPT_INFO_WIDTH = 8,
  parameter int ASID_WIDTH      = 9,
  parameter int FIFO_DEPTH      = 8
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       req0_valid,
  output logic                       req0_ready,
  input  logic [31:0]                req0_start_full_PC,
  input  logic [ASID_WIDTH-1:0]      req0_ASID,
  input  logic [MDPT_INFO_WIDTH-1:0] req0_mdp_info,
  input  logic                       req1_valid,
  output logic                       req1_ready,
  input  logic [31:0]                req1_start_full_PC,
  input  logic [ASID_WIDTH-1:0]      req1_ASID,
  input  logic [MDPT_INFO_WIDTH-1:0] req1_mdp_info,
  input  logic                       clear_req,
  output logic                       sweep_busy,
  output logic                       sweep_done,
  output logic                       dep_update0_valid,
  output logic [31:0]                dep_update0_start_full_PC,
  output logic [ASID_WIDTH-1:0]      dep_update0_ASID,
  output logic [MDPT_INFO_WIDTH-1:0] dep_update0_mdp_info
);
  localparam int IDXW = $clog2(MDPT_ENTRIES);
  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int CW   = PW + 1;

  // Handshake: a request transfers on any cycle where valid & ready; the mdpt port has
  // no ready and takes every cycle dep_update0_valid is high. sweep_busy mirrors the FSM state.
  typedef enum logic {S_IDLE, S_SWEEP} state_t;

  state_t                     r_state, w_state_nxt;
  logic [IDXW-1:0]            r_sweep_ctr;
  logic                       r_sweep_done;
  logic [31:0]                r_pc   [FIFO_DEPTH];
  logic [ASID_WIDTH-1:0]      r_asid [FIFO_DEPTH];
  logic [MDPT_INFO_WIDTH-1:0] r_info [FIFO_DEPTH];
  logic [PW-1:0]              r_head, r_tail;
  logic [CW-1:0]              r_count;

  logic          w_acc0, w_acc1, w_deq, w_flush, w_sweep_last;
  logic [PW-1:0] w_tail1;

  // Readies look only at the registered count, never crediting a same-cycle dequeue.
  assign req0_ready   = !clear_req && (r_count <= CW'(FIFO_DEPTH - 1));
  assign req1_ready   = !clear_req && (r_count <= CW'(FIFO_DEPTH - 2));
  assign w_acc0       = req0_valid && req0_ready;
  assign w_acc1       = req1_valid && req1_ready;
  assign w_deq        = (r_state == S_IDLE) && (r_count != '0);
  assign w_flush      = (r_state == S_IDLE) && clear_req;
  assign w_tail1      = r_tail + {{(PW-1){1'b0}}, w_acc0};
  assign w_sweep_last = (r_sweep_ctr == IDXW'(MDPT_ENTRIES - 1));
  assign sweep_busy   = (r_state == S_SWEEP);
  assign sweep_done   = r_sweep_done;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (clear_req) w_state_nxt = S_SWEEP;
      S_SWEEP: if (w_sweep_last) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    dep_update0_valid         = 1'b0;
    dep_update0_start_full_PC = '0;
    dep_update0_ASID          = '0;
    dep_update0_mdp_info      = '0;
    case (r_state)
      S_IDLE: begin
        dep_update0_valid         = (r_count != '0);
        dep_update0_start_full_PC = r_pc[r_head];
        dep_update0_ASID          = r_asid[r_head];
        dep_update0_mdp_info      = r_info[r_head];
      end
      S_SWEEP: begin
        // With ASID 0 the mdpt index hash reduces to PC[12:1], so the counter walks every entry.
        dep_update0_valid         = 1'b1;
        dep_update0_start_full_PC = {{(31-IDXW){1'b0}}, r_sweep_ctr, 1'b0};
      end
      default: dep_update0_valid = 1'b0;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state      <= S_IDLE;
      r_sweep_ctr  <= '0;
      r_sweep_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_sweep_done <= (r_state == S_SWEEP) && w_sweep_last;
      if (r_state == S_SWEEP)
        r_sweep_ctr <= w_sweep_last ? '0 : r_sweep_ctr + {{(IDXW-1){1'b0}}, 1'b1};
      else
        r_sweep_ctr <= '0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_pc[i]   <= '0;
        r_asid[i] <= '0;
        r_info[i] <= '0;
      end
    end else begin
      if (w_acc0) begin
        r_pc[r_tail]   <= req0_start_full_PC;
        r_asid[r_tail] <= req0_ASID;
        r_info[r_tail] <= req0_mdp_info;
      end
      if (w_acc1) begin
        r_pc[w_tail1]   <= req1_start_full_PC;
        r_asid[w_tail1] <= req1_ASID;
        r_info[w_tail1] <= req1_mdp_info;
      end
      if (w_flush) begin
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
      end else begin
        r_head  <= r_head + {{(PW-1){1'b0}}, w_deq};
        r_tail  <= w_tail1 + {{(PW-1){1'b0}}, w_acc1};
        r_count <= r_count + {{PW{1'b0}}, w_acc0} + {{PW{1'b0}}, w_acc1} - {{PW{1'b0}}, w_deq};
      end
    end
  end
endmodule

// File: tb/tb_mdpt_update_ctrl.sv
// Directed bench for mdpt_update_ctrl: queue-level reference model checked every cycle,
// plus hand-computed literal checks for each scenario.
module tb_mdpt_update_ctrl;
  localparam int W = 49;  // {PC[31:0], ASID[8:0], info[7:0]}
  localparam logic [31:0] PC_E2 = 32'hE2E2_0002;
  localparam logic [31:0] PC_A5 = 32'hCAFE_0A5B;

  logic        CLK, RST;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] req0_start_full_PC, req1_start_full_PC;
  logic [8:0]  req0_ASID, req1_ASID;
  logic [7:0]  req0_mdp_info, req1_mdp_info;
  logic        clear_req, sweep_busy, sweep_done;
  logic        dep_update0_valid;
  logic [31:0] dep_update0_start_full_PC;
  logic [8:0]  dep_update0_ASID;
  logic [7:0]  dep_update0_mdp_info;

  int tests = 0;
  int bad   = 0;

  logic [W-1:0] exp_q[$];
  bit m_sweep = 0;
  int m_idx   = 0;
  bit m_done  = 0;
  bit saw_e2  = 0;

  mdpt_update_ctrl dut (
    .CLK(CLK), .RST(RST),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_start_full_PC(req0_start_full_PC), .req0_ASID(req0_ASID), .req0_mdp_info(req0_mdp_info),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_start_full_PC(req1_start_full_PC), .req1_ASID(req1_ASID), .req1_mdp_info(req1_mdp_info),
    .clear_req(clear_req), .sweep_busy(sweep_busy), .sweep_done(sweep_done),
    .dep_update0_valid(dep_update0_valid),
    .dep_update0_start_full_PC(dep_update0_start_full_PC),
    .dep_update0_ASID(dep_update0_ASID),
    .dep_update0_mdp_info(dep_update0_mdp_info)
  );

  // ---------------- clock / reset ----------------
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    req0_valid = 0; req0_start_full_PC = '0; req0_ASID = '0; req0_mdp_info = '0;
    req1_valid = 0; req1_start_full_PC = '0; req1_ASID = '0; req1_mdp_info = '0;
    clear_req  = 0;
  endtask

  task automatic drive0(input logic [31:0] pc, input logic [8:0] asid, input logic [7:0] info);
    req0_valid = 1; req0_start_full_PC = pc; req0_ASID = asid; req0_mdp_info = info;
  endtask

  task automatic drive1(input logic [31:0] pc, input logic [8:0] asid, input logic [7:0] info);
    req1_valid = 1; req1_start_full_PC = pc; req1_ASID = asid; req1_mdp_info = info;
  endtask

  task automatic random_inputs();
    req0_valid = 1'($urandom_range(0, 1)); req0_start_full_PC = $urandom;
    req0_ASID = 9'($urandom_range(0, 511)); req0_mdp_info = 8'($urandom_range(0, 255));
    req1_valid = 1'($urandom_range(0, 1)); req1_start_full_PC = $urandom;
    req1_ASID = 9'($urandom_range(0, 511)); req1_mdp_info = 8'($urandom_range(0, 255));
    clear_req = 1'($urandom_range(0, 1));
  endtask

  // ---------------- reference model (queue level) ----------------
  initial begin : model
    forever begin
      bit a0, a1;
      @(posedge CLK or posedge RST);
      if (RST) begin
        exp_q.delete();
        m_sweep = 0;
        m_idx   = 0;
        m_done  = 0;
      end else begin
        a0 = req0_valid && !clear_req && (exp_q.size() <= 7);
        a1 = req1_valid && !clear_req && (exp_q.size() <= 6);
        m_done = 0;
        if (m_sweep) begin
          if (m_idx == 4095) begin
            m_sweep = 0;
            m_done  = 1;
          end else begin
            m_idx++;
          end
        end else if (clear_req) begin
          exp_q.delete();
          m_sweep = 1;
          m_idx   = 0;
        end else if (exp_q.size() != 0) begin
          void'(exp_q.pop_front());
        end
        if (a0) exp_q.push_back({req0_start_full_PC, req0_ASID, req0_mdp_info});
        if (a1) exp_q.push_back({req1_start_full_PC, req1_ASID, req1_mdp_info});
      end
    end
  end

  // ---------------- scoreboard compare, every cycle ----------------
  initial begin : compare
    forever begin
      logic [W-1:0] h;
      @(negedge CLK);
      chk("valid", dep_update0_valid, m_sweep || (exp_q.size() != 0));
      chk("ready0", req0_ready, !clear_req && (exp_q.size() <= 7));
      chk("ready1", req1_ready, !clear_req && (exp_q.size() <= 6));
      chk("busy", sweep_busy, m_sweep);
      chk("done", sweep_done, m_done);
      if (m_sweep) begin
        chk("sweep_pc", dep_update0_start_full_PC, 32'(m_idx * 2));
        chk("sweep_asid", dep_update0_ASID, 0);
        chk("sweep_info", dep_update0_mdp_info, 0);
      end else if (exp_q.size() != 0) begin
        h = exp_q[0];
        chk("pc", dep_update0_start_full_PC, h[48:17]);
        chk("asid", dep_update0_ASID, h[16:8]);
        chk("info", dep_update0_mdp_info, h[7:0]);
      end
      if (dep_update0_valid && dep_update0_start_full_PC == PC_E2) saw_e2 = 1;
    end
  end

  // ---------------- directed stimulus ----------------
  initial begin : stim
    int nsweep;
    int ndone;
    RST = 1;
    idle_inputs();

    // Reset with random inputs.
    for (int k = 0; k < 3; k++) begin
      random_inputs();
      @(negedge CLK);
      chk("rst_valid", dep_update0_valid, 0);
      chk("rst_pc", dep_update0_start_full_PC, 0);
      chk("rst_asid", dep_update0_ASID, 0);
      chk("rst_info", dep_update0_mdp_info, 0);
      chk("rst_busy", sweep_busy, 0);
      @(posedge CLK);
      #1;
    end
    idle_inputs();
    RST = 0;
    @(negedge CLK);
    chk("post_rst_ready0", req0_ready, 1);
    chk("post_rst_ready1", req1_ready, 1);
    tick();

    // Single update.
    drive0(32'h0000_1ABE, 9'h1FF, 8'h5C);
    tick();
    idle_inputs();
    @(negedge CLK);
    chk("single_valid", dep_update0_valid, 1);
    chk("single_pc", dep_update0_start_full_PC, 32'h0000_1ABE);
    chk("single_asid", dep_update0_ASID, 9'h1FF);
    chk("single_info", dep_update0_mdp_info, 8'h5C);
    tick();
    @(negedge CLK);
    chk("single_after", dep_update0_valid, 0);
    tick();

    // Dual enqueue order.
    drive0(32'h0000_0100, 9'h001, 8'h11);
    drive1(32'h0000_0200, 9'h002, 8'h22);
    tick();
    idle_inputs();
    drive0(32'h0000_0300, 9'h003, 8'h33);
    @(negedge CLK);
    chk("dual_first", dep_update0_mdp_info, 8'h11);
    tick();
    idle_inputs();
    @(negedge CLK);
    chk("dual_second", dep_update0_mdp_info, 8'h22);
    tick();
    @(negedge CLK);
    chk("dual_third", dep_update0_mdp_info, 8'h33);
    tick();
    @(negedge CLK);
    chk("dual_empty", dep_update0_valid, 0);
    tick();

    // Backpressure in IDLE: count walks 0,2,3,4,5,6,7 then holds at 7.
    for (int k = 0; k < 20; k++) begin
      drive0(32'h1000_0000 | 32'(k << 4), 9'(k), 8'(2 * k));
      drive1(32'h2000_0001 | 32'(k << 4), 9'(k + 100), 8'(2 * k + 1));
      @(negedge CLK);
      if (k == 5) chk("bp_ready1_at6", req1_ready, 1);
      if (k == 6) chk("bp_ready1_at7", req1_ready, 0);
      if (k == 6) chk("bp_ready0_at7", req0_ready, 1);
      @(posedge CLK);
      #1;
    end
    idle_inputs();
    repeat (10) tick();
    @(negedge CLK);
    chk("bp_drained", dep_update0_valid, 0);
    tick();

    // Clear sweep: E1 drains in the clear cycle, E2 is flushed.
    drive0(32'hE1E1_0001, 9'h0E1, 8'hE1);
    drive1(PC_E2, 9'h0E2, 8'hE2);
    tick();
    idle_inputs();
    clear_req = 1;
    tick();
    idle_inputs();
    nsweep = 0;
    for (int i = 0; i < 4096; i++) begin
      idle_inputs();
      if (i == 100) drive0(PC_A5, 9'h0A5, 8'hA5);
      if (i >= 101 && i <= 105) begin
        drive0(32'h3000_0000 | 32'(i << 4), 9'(i), 8'(2 * i));
        drive1(32'h4000_0001 | 32'(i << 4), 9'(i + 1), 8'(2 * i + 1));
      end
      if (i == 2000) clear_req = 1;
      @(negedge CLK);
      if (dep_update0_valid && sweep_busy && dep_update0_start_full_PC == 32'(i * 2)) nsweep++;
      if (i == 103) chk("sw_ready1_at5", req1_ready, 1);
      if (i == 104) chk("sw_ready1_at7", req1_ready, 0);
      if (i == 104) chk("sw_ready0_at7", req0_ready, 1);
      if (i == 105) chk("sw_ready0_at8", req0_ready, 0);
      @(posedge CLK);
      #1;
    end
    idle_inputs();
    @(negedge CLK);
    chk("sweep_writes", nsweep, 4096);
    chk("sweep_done_pulse", sweep_done, 1);
    chk("sweep_busy_end", sweep_busy, 0);
    chk("a5_valid", dep_update0_valid, 1);
    chk("a5_pc", dep_update0_start_full_PC, PC_A5);
    chk("a5_info", dep_update0_mdp_info, 8'hA5);
    tick();
    @(negedge CLK);
    chk("sweep_done_once", sweep_done, 0);
    repeat (10) tick();
    chk("e2_never_written", saw_e2, 0);

    // Reset mid-sweep at sweep_ctr = 0x100.
    clear_req = 1;
    tick();
    clear_req = 0;
    repeat (256) tick();
    chk("mid_pc", dep_update0_start_full_PC, 32'h0000_0200);
    chk("mid_busy", sweep_busy, 1);
    RST = 1;
    #1;
    chk("mid_rst_valid", dep_update0_valid, 0);
    chk("mid_rst_busy", sweep_busy, 0);
    repeat (2) tick();
    RST = 0;
    ndone = 0;
    for (int i = 0; i < 4200; i++) begin
      @(negedge CLK);
      if (sweep_done) ndone++;
    end
    chk("no_done_after_rst", ndone, 0);

    $display("test done: total=%0d bad=%0d", tests, bad);
    $finish;
  end
endmodule
